char_sweep_sequencer: RTL and testbench

//  Sits between the AXI config block and the neuromorphic ASIC: drives char_select to the ASIC through all four

---
 rtl/char_sweep_sequencer.sv | 146 ++++++++++++++
 tb/tb_char_sweep_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/char_sweep_sequencer.sv
// Sweeps char_select through the four ASIC characters, lets each settle, samples the
// synchronised network_output and keeps saturating hit/miss counts against expected_map.
module char_sweep_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1000,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESETN,
  input  logic                 start,
  input  logic                 abort,
  input  logic [7:0]           num_sweeps,
  input  logic [7:0]           expected_map,
  input  logic [1:0]           char_select_cfg,
  input  logic [1:0]           network_output,
  output logic [1:0]           char_select,
  output logic                 busy,
  output logic                 done,
  output logic                 sample_strobe,
  output logic [1:0]           last_result,
  output logic [CNT_WIDTH-1:0] match_count,
  output logic [CNT_WIDTH-1:0] mismatch_count
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]        SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_APPLY, S_SETTLE, S_SAMPLE, S_CHECK, S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [7:0]           sweep_q, sweep_d;
  logic [SW-1:0]        settle_q, settle_d;
  logic [1:0]           sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]           last_q, last_d;
  logic [CNT_WIDTH-1:0] match_q, match_d, mismatch_q, mismatch_d;
  logic                 busy_q, busy_d, done_q, done_d, strobe_q, strobe_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    sweep_d    = sweep_q;
    settle_d   = settle_q;
    last_d     = last_q;
    match_d    = match_q;
    mismatch_d = mismatch_q;
    sync1_d    = network_output;
    sync2_d    = sync1_q;

    // abort outranks everything; in IDLE it also masks a simultaneous start
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d    = S_APPLY;
            idx_d      = 2'd0;
            sweep_d    = 8'd0;
            match_d    = '0;
            mismatch_d = '0;
          end
        end
        S_APPLY: begin
          settle_d = SETTLE_LOAD;
          state_d  = S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_q == '0) state_d = S_SAMPLE;
          else                settle_d = settle_q - 1'b1;
        end
        S_SAMPLE: begin
          last_d  = sync2_q;
          state_d = S_CHECK;
        end
        S_CHECK: begin
          if (last_q == expected_map[{idx_q, 1'b0} +: 2]) begin
            if (match_q != CNT_MAX) match_d = match_q + 1'b1;
          end else begin
            if (mismatch_q != CNT_MAX) mismatch_d = mismatch_q + 1'b1;
          end
          if (idx_q != 2'd3) begin
            idx_d   = idx_q + 2'd1;
            state_d = S_APPLY;
          end else begin
            idx_d   = 2'd0;
            sweep_d = sweep_q + 8'd1;
            // 9-bit compare so a 255->0 wrap can never look like completion
            if (num_sweeps != 8'd0 && ({1'b0, sweep_q} + 9'd1) == {1'b0, num_sweeps})
              state_d = S_DONE;
            else
              state_d = S_APPLY;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    strobe_d = (state_d == S_CHECK);
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= S_IDLE;
      idx_q      <= 2'd0;
      sweep_q    <= 8'd0;
      settle_q   <= '0;
      sync1_q    <= 2'd0;
      sync2_q    <= 2'd0;
      last_q     <= 2'd0;
      match_q    <= '0;
      mismatch_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sweep_q    <= sweep_d;
      settle_q   <= settle_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      last_q     <= last_d;
      match_q    <= match_d;
      mismatch_q <= mismatch_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      strobe_q   <= strobe_d;
    end
  end

  // idx_q is stable from APPLY through CHECK, so the ASIC sees no glitch within a char
  assign char_select    = busy_q ? idx_q : char_select_cfg;
  assign busy           = busy_q;
  assign done           = done_q;
  assign sample_strobe  = strobe_q;
  assign last_result    = last_q;
  assign match_count    = match_q;
  assign mismatch_count = mismatch_q;

endmodule

// File: tb/tb_char_sweep_sequencer.sv
// Bench for char_sweep_sequencer: table-driven runs, random runs against a per-char
// scoring model, and hand sequences for abort, mid-run reset and synchroniser latency.
module tb_char_sweep_sequencer;

  localparam int S   = 4;
  localparam int PER = S + 3;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, echo_en;
  logic [7:0] num_sweeps, expected_map, resp_tbl;
  logic [1:0] char_select_cfg, force_val, network_output;

  logic [1:0]  char_select, last_result, s_char_select, s_last_result;
  logic        busy, done, sample_strobe, s_busy, s_done, s_sample_strobe;
  logic [15:0] match_count, mismatch_count;
  logic [2:0]  s_match_count, s_mismatch_count;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // ASIC model: each char maps to a fixed response, or a directly forced value
  assign network_output = echo_en ? resp_tbl[{char_select, 1'b0} +: 2] : force_val;

  char_sweep_sequencer #(.SETTLE_CYCLES(S), .CNT_WIDTH(16)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start), .abort(abort),
    .num_sweeps(num_sweeps), .expected_map(expected_map),
    .char_select_cfg(char_select_cfg), .network_output(network_output),
    .char_select(char_select), .busy(busy), .done(done), .sample_strobe(sample_strobe),
    .last_result(last_result), .match_count(match_count), .mismatch_count(mismatch_count));

  char_sweep_sequencer #(.SETTLE_CYCLES(S), .CNT_WIDTH(3)) dut_s (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start), .abort(abort),
    .num_sweeps(num_sweeps), .expected_map(expected_map),
    .char_select_cfg(char_select_cfg), .network_output(network_output),
    .char_select(s_char_select), .busy(s_busy), .done(s_done),
    .sample_strobe(s_sample_strobe), .last_result(s_last_result),
    .match_count(s_match_count), .mismatch_count(s_mismatch_count));

  typedef struct {
    string      name;
    logic [7:0] ns;
    logic [7:0] em;
    logic [7:0] rt;
    int         m;
    int         mm;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Launches a run and follows it to done, checking timing, char order and counts.
  task automatic run(input string nm, input logic [7:0] ns, input logic [7:0] em,
                     input logic [7:0] rt, input int exp_m, input int exp_mm);
    int cyc, strobes, bad_sel, done_cyc, limit;
    num_sweeps = ns; expected_map = em; resp_tbl = rt; echo_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1; strobes = 0; bad_sel = 0; done_cyc = 0;
    limit = 4 * int'(ns) * PER + 50;
    while (cyc < limit) begin
      if (sample_strobe) strobes++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (int'(char_select) != ((cyc - 1) / PER) % 4) bad_sel++;
      tick();
      cyc++;
    end
    chk({nm, " done_cycle"}, done_cyc, 4 * int'(ns) * PER + 1);
    chk({nm, " strobes"}, strobes, 4 * int'(ns));
    chk({nm, " char_seq_errs"}, bad_sel, 0);
    chk({nm, " match"}, int'(match_count), exp_m);
    chk({nm, " mismatch"}, int'(mismatch_count), exp_mm);
    chk({nm, " match_sat3"}, int'(s_match_count), sat(exp_m, 7));
    chk({nm, " mismatch_sat3"}, int'(s_mismatch_count), sat(exp_mm, 7));
    tick();
    chk({nm, " busy_after"}, int'(busy), 0);
    chk({nm, " done_1cyc"}, int'(done), 0);
  endtask

  vec_t vecs[5];

  initial begin
    int          m, saw_done;
    logic [7:0]  ns, em, rt;

    vecs[0] = '{"t1_one_sweep",  8'd1, 8'hE4, 8'hE4, 4, 0};
    vecs[1] = '{"t2_two_sweeps", 8'd2, 8'h00, 8'hE4, 2, 6};
    vecs[2] = '{"t5_saturate",   8'd3, 8'hE4, 8'hE4, 12, 0};
    vecs[3] = '{"all_miss",      8'd1, 8'h1B, 8'hE4, 0, 4};
    vecs[4] = '{"all_three",     8'd2, 8'hFF, 8'hFF, 8, 0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; echo_en = 1'b1;
    num_sweeps = 8'd0; expected_map = 8'd0; resp_tbl = 8'hE4;
    char_select_cfg = 2'd1; force_val = 2'd0;
    tick(); tick();
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst strobe", int'(sample_strobe), 0);
    chk("rst last_result", int'(last_result), 0);
    chk("rst match", int'(match_count), 0);
    chk("rst mismatch", int'(mismatch_count), 0);
    chk("rst char_select_cfg", int'(char_select), 1);
    char_select_cfg = 2'd2;
    #1;
    chk("idle passthrough", int'(char_select), 2);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) run(vecs[i].name, vecs[i].ns, vecs[i].em, vecs[i].rt, vecs[i].m, vecs[i].mm);

    // random runs scored by a per-char model: each char contributes ns hits or ns misses
    for (int it = 0; it < 6; it++) begin
      ns = 8'($urandom_range(1, 3));
      em = 8'($urandom);
      rt = 8'($urandom);
      char_select_cfg = 2'($urandom);
      m = 0;
      for (int k = 0; k < 4; k++)
        if (rt[2*k +: 2] == em[2*k +: 2]) m += int'(ns);
      run($sformatf("rand%0d", it), ns, em, rt, m, 4 * int'(ns) - m);
    end

    // abort an endless run at clock 100
    char_select_cfg = 2'd2; num_sweeps = 8'd0; expected_map = 8'hE4; resp_tbl = 8'hE4;
    start = 1'b1;
    tick();
    start = 1'b0;
    saw_done = 0;
    repeat (99) begin
      if (done) saw_done = 1;
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort busy", int'(busy), 0);
    chk("abort char_select_cfg", int'(char_select), 2);
    chk("abort match", int'(match_count), 14);
    chk("abort mismatch", int'(mismatch_count), 0);
    chk("abort no_done", saw_done + int'(done), 0);
    repeat (5) tick();
    chk("abort frozen", int'(match_count) + int'(mismatch_count), 14);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort+start busy", int'(busy), 0);
    chk("abort+start keep", int'(match_count), 14);

    // reset in the middle of char 2's settle window
    char_select_cfg = 2'd3; num_sweeps = 8'd1; expected_map = 8'hE4;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    chk("pre_rst char_select", int'(char_select), 2);
    chk("pre_rst last_result", int'(last_result), 1);
    rst_n = 1'b0;
    tick();
    chk("midrst busy", int'(busy), 0);
    chk("midrst last_result", int'(last_result), 0);
    chk("midrst counts", int'(match_count) + int'(mismatch_count), 0);
    chk("midrst strobe_done", int'(sample_strobe) + int'(done), 0);
    chk("midrst char_select", int'(char_select), 3);
    rst_n = 1'b1;
    tick();
    run("after_rst", 8'd1, 8'hE4, 8'hE4, 4, 0);

    // network_output changes one clock before SAMPLE: the old value must be captured
    echo_en = 1'b0; force_val = 2'd0; expected_map = 8'h00; num_sweeps = 8'd1;
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    force_val = 2'd3;
    tick();
    tick();
    chk("sync strobe", int'(sample_strobe), 1);
    chk("sync pre_toggle", int'(last_result), 0);
    repeat (7) tick();
    chk("sync post_toggle", int'(last_result), 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("sync abort idle", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
